branch_predictor: RTL and testbench

Dynamic branch predictor and misprediction-recovery unit for the RISC-V core. It produces `br_pred_taken` for the IF-stage PC register, and `mispredict` plus `restore_addr` for the PC register's restore path. Prediction uses a direct-mapped table of 2-bit saturating counters indexed by PC. The table is trained by branch resolutions from EX, and the unit keeps branch and mispredict statistics for CSR readout.

---
 rtl/branch_predictor.sv | 157 +++++++++++++++
 tb/tb_branch_predictor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Dynamic branch predictor and misprediction-recovery unit.
//               A direct-mapped table of 2-bit saturating counters, indexed
//               by PC bits [IDX_BITS+1:2], predicts conditional branches in
//               IF. Resolutions from EX train the table, flag mispredicts,
//               supply the restore PC and drive branch/mispredict statistics.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   IDX_BITS      table index width (table holds 2**IDX_BITS counters)
//   RESET_CTR     counter value loaded into every entry on reset
// Ports
//   clk           in   1   core clock, rising-edge active
//   rst_n         in   1   synchronous active-low reset
//   if_pc         in   32  PC of the instruction in IF
//   if_inst       in   32  instruction word in IF
//   br_pred_taken out  1   predict taken for the IF instruction
//   ex_valid      in   1   conditional branch resolving in EX
//   ex_pc         in   32  PC of the resolving branch
//   ex_taken      in   1   actual outcome
//   ex_pred_taken in   1   prediction carried down from IF
//   ex_target     in   32  computed branch target
//   mispredict    out  1   outcome disagrees with prediction
//   restore_addr  out  32  correct next PC after a mispredict
//   br_cnt        out  32  resolved-branch count
//   mis_cnt       out  32  mispredicted-branch count
// ============================================================================
module branch_predictor #(
    parameter int         IDX_BITS  = 6,
    parameter logic [1:0] RESET_CTR = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic        br_pred_taken,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_target,
    output logic        mispredict,
    output logic [31:0] restore_addr,
    output logic [31:0] br_cnt,
    output logic [31:0] mis_cnt
);

    localparam int         c_NUM_ENTRIES = 1 << IDX_BITS;
    localparam logic [6:0] c_OP_BRANCH   = 7'b1100011;
    localparam logic [1:0] c_CTR_MAX     = 2'b11;
    localparam logic [1:0] c_CTR_MIN     = 2'b00;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_ctr_q [c_NUM_ENTRIES];
    logic [1:0]          w_ctr_d [c_NUM_ENTRIES];
    logic [31:0]         r_br_cnt_q;
    logic [31:0]         w_br_cnt_d;
    logic [31:0]         r_mis_cnt_q;
    logic [31:0]         w_mis_cnt_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [IDX_BITS-1:0] w_lookup_idx;
    logic [IDX_BITS-1:0] w_upd_idx;
    logic [1:0]          w_lookup_ctr;
    logic [1:0]          w_upd_ctr;
    logic [1:0]          w_upd_ctr_next;
    logic                w_is_br;
    logic                w_mispredict;

    // PC bits outside the index and the non-opcode instruction bits do not
    // participate in prediction; they are collected here so they are visibly
    // consumed.
    logic                w_unused_bits;
    assign w_unused_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0],
                             if_inst[31:7], ex_pc[1:0]};

    assign w_lookup_idx = if_pc[IDX_BITS+1:2];
    assign w_upd_idx    = ex_pc[IDX_BITS+1:2];
    assign w_is_br      = (if_inst[6:0] == c_OP_BRANCH);

    // Lookup reads the registered table directly: a same-cycle update to the
    // same index is not bypassed, so the prediction sees the old counter.
    assign w_lookup_ctr = r_ctr_q[w_lookup_idx];
    assign w_upd_ctr    = r_ctr_q[w_upd_idx];

    assign w_mispredict = rst_n & ex_valid & (ex_taken != ex_pred_taken);

    // Prediction is suppressed during a mispredict so the restore path takes
    // priority in the PC register's select logic.
    assign br_pred_taken = rst_n & w_is_br & w_lookup_ctr[1] & ~w_mispredict;
    assign mispredict    = w_mispredict;

    // Fall-through address wraps naturally in 32 bits.
    assign restore_addr  = ex_taken ? ex_target : (ex_pc + 32'd4);

    assign br_cnt        = r_br_cnt_q;
    assign mis_cnt       = r_mis_cnt_q;

    // ------------------------------------------------------------------------
    // Next-state: counter training and statistics
    // ------------------------------------------------------------------------
    always_comb begin
        w_upd_ctr_next = w_upd_ctr;
        if (ex_taken) begin
            if (w_upd_ctr != c_CTR_MAX) begin
                w_upd_ctr_next = w_upd_ctr + 2'd1;
            end
        end else begin
            if (w_upd_ctr != c_CTR_MIN) begin
                w_upd_ctr_next = w_upd_ctr - 2'd1;
            end
        end
    end

    always_comb begin
        w_ctr_d = r_ctr_q;
        if (ex_valid) begin
            w_ctr_d[w_upd_idx] = w_upd_ctr_next;
        end
    end

    always_comb begin
        w_br_cnt_d  = r_br_cnt_q;
        w_mis_cnt_d = r_mis_cnt_q;
        if (ex_valid) begin
            w_br_cnt_d = r_br_cnt_q + 32'd1;
        end
        if (w_mispredict) begin
            w_mis_cnt_d = r_mis_cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers; reset overrides any resolution presented in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_ENTRIES; i++) begin
                r_ctr_q[i] <= RESET_CTR;
            end
            r_br_cnt_q  <= 32'd0;
            r_mis_cnt_q <= 32'd0;
        end else begin
            r_ctr_q     <= w_ctr_d;
            r_br_cnt_q  <= w_br_cnt_d;
            r_mis_cnt_q <= w_mis_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam logic [31:0] c_BEQ  = 32'h0000_0063;
    localparam logic [31:0] c_ADDI = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        br_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [31:0] ex_target;
    logic        mispredict;
    logic [31:0] restore_addr;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;

    int total;
    int bad;

    branch_predictor #(
        .IDX_BITS  (6),
        .RESET_CTR (2'b01)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .br_pred_taken (br_pred_taken),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .mispredict    (mispredict),
        .restore_addr  (restore_addr),
        .br_cnt        (br_cnt),
        .mis_cnt       (mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk,
                          input logic pt, input logic [31:0] tgt);
        ex_valid      = v;
        ex_pc         = pc;
        ex_taken      = tk;
        ex_pred_taken = pt;
        ex_target     = tgt;
    endtask

    task automatic set_if(input logic [31:0] pc, input logic [31:0] inst);
        if_pc   = pc;
        if_inst = inst;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_if(32'h0, c_BEQ);
        // Mispredicting resolution held during reset must be ignored.
        set_ex(1'b1, 32'h4000_0010, 1'b1, 1'b0, 32'h4000_0040);
        @(negedge clk);
        #1;
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_pred", {31'd0, br_pred_taken}, 32'd0);
        cyc();
        cyc();

        // ---- Reset state ----
        rst_n = 1'b1;
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_if(32'h4000_0010, c_BEQ);
        #1;
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_mis_cnt", mis_cnt, 32'd0);
        chk("rst_pred_beq", {31'd0, br_pred_taken}, 32'd0);

        // ---- Training: first taken resolution, predicted not-taken ----
        set_ex(1'b1, 32'h4000_0010, 1'b1, 1'b0, 32'h4000_0040);
        #1;
        chk("tr1_mispredict", {31'd0, mispredict}, 32'd1);
        chk("tr1_restore", restore_addr, 32'h4000_0040);
        cyc();
        // Entry now 10; ex_valid=0 with disagreeing ex_* must not mispredict.
        set_ex(1'b0, 32'h4000_0010, 1'b1, 1'b0, 32'h4000_0040);
        #1;
        chk("tr_pred_after1", {31'd0, br_pred_taken}, 32'd1);
        chk("idle_mispredict", {31'd0, mispredict}, 32'd0);
        cyc();
        set_ex(1'b1, 32'h4000_0010, 1'b1, 1'b0, 32'h4000_0040);
        #1;
        chk("tr2_mispredict", {31'd0, mispredict}, 32'd1);
        cyc();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("tr_br_cnt", br_cnt, 32'd2);
        chk("tr_mis_cnt", mis_cnt, 32'd2);

        // ---- Saturation: five more taken, correctly predicted ----
        for (int i = 0; i < 5; i++) begin
            set_ex(1'b1, 32'h4000_0010, 1'b1, 1'b1, 32'h4000_0040);
            #1;
            chk("sat_no_mispredict", {31'd0, mispredict}, 32'd0);
            cyc();
        end
        // Not-taken with predicted taken: fall-through restore.
        set_ex(1'b1, 32'h4000_0010, 1'b0, 1'b1, 32'h4000_0040);
        #1;
        chk("nt_mispredict", {31'd0, mispredict}, 32'd1);
        chk("nt_restore", restore_addr, 32'h4000_0014);
        cyc();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("sat_pred_still_t", {31'd0, br_pred_taken}, 32'd1);
        chk("sat_br_cnt", br_cnt, 32'd8);
        chk("sat_mis_cnt", mis_cnt, 32'd3);

        // ---- Same-cycle lookup/update, fresh index 8 (counter 01) ----
        set_if(32'h4000_0020, c_BEQ);
        set_ex(1'b1, 32'h4000_0020, 1'b1, 1'b1, 32'h4000_0080);
        #1;
        chk("conf_old_val_nt", {31'd0, br_pred_taken}, 32'd0);
        cyc();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("conf_new_val_t", {31'd0, br_pred_taken}, 32'd1);
        cyc();
        // Counter 10 -> 01 while looked up in the same cycle.
        set_ex(1'b1, 32'h4000_0020, 1'b0, 1'b0, 32'h4000_0080);
        #1;
        chk("conf_old_val_t", {31'd0, br_pred_taken}, 32'd1);
        cyc();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("conf_new_val_nt", {31'd0, br_pred_taken}, 32'd0);

        // ---- Prediction suppressed during mispredict, strong-T entry ----
        set_ex(1'b1, 32'h4000_0010, 1'b1, 1'b1, 32'h4000_0040);   // idx4 10 -> 11
        cyc();
        set_if(32'h4000_0010, c_BEQ);
        set_ex(1'b1, 32'h4000_0030, 1'b1, 1'b0, 32'h4000_0100);
        #1;
        chk("supp_mispredict", {31'd0, mispredict}, 32'd1);
        chk("supp_pred", {31'd0, br_pred_taken}, 32'd0);
        chk("supp_restore", restore_addr, 32'h4000_0100);
        cyc();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("strong_t_pred", {31'd0, br_pred_taken}, 32'd1);
        set_if(32'h4000_0010, c_ADDI);
        #1;
        chk("non_branch_pred", {31'd0, br_pred_taken}, 32'd0);
        set_if(32'h4000_0110, c_BEQ);                         // aliases index 4
        #1;
        chk("alias_pred", {31'd0, br_pred_taken}, 32'd1);

        // ---- Address wrap on fall-through ----
        set_ex(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234_5678);
        #1;
        chk("wrap_mispredict", {31'd0, mispredict}, 32'd1);
        chk("wrap_restore", restore_addr, 32'h0000_0000);
        cyc();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("wrap_br_cnt", br_cnt, 32'd13);
        chk("wrap_mis_cnt", mis_cnt, 32'd5);

        // ---- Branch counter wrap from a preloaded value ----
        force dut.r_br_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.r_br_cnt_q;
        set_ex(1'b1, 32'h4000_0200, 1'b1, 1'b1, 32'h4000_0300);
        cyc();
        #1;
        chk("cnt_ffffffff", br_cnt, 32'hFFFF_FFFF);
        cyc();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("cnt_wrap_zero", br_cnt, 32'd0);
        chk("cnt_wrap_mis", mis_cnt, 32'd5);

        // ---- Reset mid-stream with a mispredicting resolution ----
        set_if(32'h4000_0010, c_BEQ);
        rst_n = 1'b0;
        set_ex(1'b1, 32'h4000_0010, 1'b0, 1'b1, 32'h4000_0040);
        #1;
        chk("mid_rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("mid_rst_pred", {31'd0, br_pred_taken}, 32'd0);
        cyc();
        #1;
        chk("mid_rst_br_cnt", br_cnt, 32'd0);
        chk("mid_rst_mis_cnt", mis_cnt, 32'd0);
        for (int i = 0; i < 64; i++) begin
            chk("mid_rst_entry", {30'd0, dut.r_ctr_q[i]}, 32'd1);
        end
        rst_n = 1'b1;
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("post_rst_pred", {31'd0, br_pred_taken}, 32'd0);
        // One taken step from 01 must reach weak-T.
        set_ex(1'b1, 32'h4000_0010, 1'b1, 1'b1, 32'h4000_0040);
        cyc();
        set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("post_rst_train", {31'd0, br_pred_taken}, 32'd1);
        chk("post_rst_br_cnt", br_cnt, 32'd1);
        set_if(32'hFFFF_FFFC, c_BEQ);
        #1;
        chk("post_rst_idx63", {31'd0, br_pred_taken}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
